// File: rtl/afu_rd_arb_pkg.sv
// -----------------------------------------------------------------------------
// afu_rd_arb_pkg
// Shared constants and helpers for the AFU read-channel arbiter.
//   SEQ_W   : width of the per-requester sequence number carried in mdata
//   ID_LSB  : bit offset of the requester id inside mdata
//   seq_lsb : bit offset of the sequence number inside mdata (sits above the id)
//   clog2w  : ceil(log2(n)), never less than 1, usable in constant expressions
// -----------------------------------------------------------------------------
package afu_rd_arb_pkg;

    localparam int SEQ_W  = 8;
    localparam int ID_LSB = 0;

    function automatic int clog2w(input int n);
        int w;
        w = 1;
        for (int i = 0; i < 31; i++) begin
            if ((1 << w) < n) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

    function automatic int seq_lsb(input int id_w);
        return ID_LSB + id_w;
    endfunction

endpackage

// File: rtl/afu_rd_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// N-wide rotating-priority arbiter. The search starts at the registered
// pointer; after a grant the pointer moves to one past the winner, so the
// winner becomes lowest priority next time.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   req          : request vector (already qualified by the caller)
//   accept       : grant permitted this cycle; when low no grant is made
//   gnt          : one-hot grant (combinational)
//   gnt_idx      : index of the granted requester
//   gnt_any      : a grant is made this cycle
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N-1:0]     req,
    input  logic             accept,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_any
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_next;
    int               idx;

    // First requesting slot at or after ptr, wrapping at N (N need not be a
    // power of two, hence the explicit wrap instead of modulo-by-width).
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (accept && !gnt_any && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = IDX_W'(idx);
                gnt_any  = 1'b1;
            end
        end
    end

    assign ptr_next = (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + IDX_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/afu_rd_arbiter.sv
// -----------------------------------------------------------------------------
// afu_rd_arbiter
// Shares one AFU read-request/response channel between NREQ requesters.
// Round-robin grant, one per cycle, gated by rd_req_almostfull and drain.
// Each issued read carries {seq, id} in mdata; responses are routed back by id
// and carry the sequence number so requesters can reorder. Outstanding reads
// are limited to MAX_OUTST per requester.
// Optional feature macro: RD_ARB_STATS_EN adds stat_clr / stat_req_cnt
// (per-requester 32-bit issued-read counters).
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   req_valid/req_addr    : requester address handshake (slice i = requester i)
//   req_ready             : one-hot grant, combinational
//   drain / idle          : barrier control: block grants / nothing in flight
//   rd_req_*              : registered AFU read request
//   rd_rsp_*              : AFU read response
//   rsp_valid/seq/data    : registered response delivery to requesters
//   err_underflow         : sticky unexpected-response flag
// -----------------------------------------------------------------------------
module afu_rd_arbiter
    import afu_rd_arb_pkg::*;
#(
    parameter int ADDR_LMT    = 20,
    parameter int MDATA       = 14,
    parameter int CACHE_WIDTH = 512,
    parameter int NREQ        = 4,
    parameter int MAX_OUTST   = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*ADDR_LMT-1:0] req_addr,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     drain,
    output logic                     idle,
`ifdef RD_ARB_STATS_EN
    input  logic                     stat_clr,
    output logic [NREQ*32-1:0]       stat_req_cnt,
`endif
    output logic [ADDR_LMT-1:0]      rd_req_addr,
    output logic [MDATA-1:0]         rd_req_mdata,
    output logic                     rd_req_en,
    input  logic                     rd_req_almostfull,
    input  logic                     rd_rsp_valid,
    input  logic [MDATA-1:0]         rd_rsp_mdata,
    input  logic [CACHE_WIDTH-1:0]   rd_rsp_data,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [SEQ_W-1:0]         rsp_seq,
    output logic [CACHE_WIDTH-1:0]   rsp_data,
    output logic                     err_underflow
);

    localparam int ID_W    = clog2w(NREQ);
    localparam int SEQ_LSB = seq_lsb(ID_W);
    localparam int CNT_W   = clog2w(MAX_OUTST + 1);

    logic [NREQ-1:0]   eligible;
    logic [NREQ-1:0]   gnt;
    logic [ID_W-1:0]   win;
    logic              gnt_any;
    logic              accept;
    logic [MDATA-1:0]  mdata_next;

    logic [CNT_W-1:0]  outst [NREQ];
    logic [SEQ_W-1:0]  seq   [NREQ];

    logic [ID_W-1:0]   rsp_id;
    logic              rsp_in_range;
    logic [NREQ-1:0]   rsp_hit;
    logic [NREQ-1:0]   rsp_dec;
    logic              rsp_err;
    logic              any_outst;

    logic                   rd_req_en_p1;
    logic [ADDR_LMT-1:0]    rd_req_addr_p1;
    logic [MDATA-1:0]       rd_req_mdata_p1;
    logic [NREQ-1:0]        rsp_valid_p1;
    logic [SEQ_W-1:0]       rsp_seq_p1;
    logic [CACHE_WIDTH-1:0] rsp_data_p1;
    logic                   err_underflow_q;

    // ---- p0: eligibility and arbitration --------------------------------
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = req_valid[i] && (outst[i] < CNT_W'(MAX_OUTST));
        end
    end

    assign accept = !rd_req_almostfull && !drain;

    rr_arbiter #(
        .N     (NREQ),
        .IDX_W (ID_W)
    ) u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (eligible),
        .accept  (accept),
        .gnt     (gnt),
        .gnt_idx (win),
        .gnt_any (gnt_any)
    );

    assign req_ready = gnt;

    always_comb begin
        mdata_next                      = '0;
        mdata_next[ID_LSB +: ID_W]      = win;
        mdata_next[SEQ_LSB +: SEQ_W]    = seq[win];
    end

    // Response decode. Delivery happens for any in-range id; the counter only
    // decrements when it is non-zero, otherwise the response is an underflow.
    assign rsp_id       = rd_rsp_mdata[ID_LSB +: ID_W];
    assign rsp_in_range = {1'b0, rsp_id} < (ID_W + 1)'(NREQ);

    always_comb begin
        rsp_hit = '0;
        rsp_dec = '0;
        rsp_err = 1'b0;
        if (rd_rsp_valid) begin
            if (!rsp_in_range) begin
                rsp_err = 1'b1;
            end else begin
                for (int i = 0; i < NREQ; i++) begin
                    if (rsp_id == ID_W'(i)) begin
                        rsp_hit[i] = 1'b1;
                        if (outst[i] == '0) begin
                            rsp_err = 1'b1;
                        end else begin
                            rsp_dec[i] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    generate
        if (MDATA > SEQ_LSB + SEQ_W) begin : g_mdata_hi
            logic unused_mdata_hi;
            assign unused_mdata_hi = ^rd_rsp_mdata[MDATA-1:SEQ_LSB+SEQ_W];
        end
    endgenerate

    // Per-requester sequence and outstanding counters; a simultaneous
    // issue and retire on the same requester leaves the count unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREQ; i++) begin
                outst[i] <= '0;
                seq[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (gnt[i] && !rsp_dec[i]) begin
                    outst[i] <= outst[i] + CNT_W'(1);
                end else if (!gnt[i] && rsp_dec[i]) begin
                    outst[i] <= outst[i] - CNT_W'(1);
                end
                if (gnt[i]) begin
                    seq[i] <= seq[i] + SEQ_W'(1);
                end
            end
        end
    end

    // ---- p1: registered request issue -----------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_req_en_p1    <= 1'b0;
            rd_req_addr_p1  <= '0;
            rd_req_mdata_p1 <= '0;
        end else begin
            rd_req_en_p1 <= gnt_any;
            if (gnt_any) begin
                rd_req_addr_p1  <= req_addr[int'(win)*ADDR_LMT +: ADDR_LMT];
                rd_req_mdata_p1 <= mdata_next;
            end
        end
    end

    // ---- p1: registered response delivery -------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid_p1    <= '0;
            rsp_seq_p1      <= '0;
            rsp_data_p1     <= '0;
            err_underflow_q <= 1'b0;
        end else begin
            rsp_valid_p1 <= rsp_hit;
            if (rd_rsp_valid) begin
                rsp_seq_p1  <= rd_rsp_mdata[SEQ_LSB +: SEQ_W];
                rsp_data_p1 <= rd_rsp_data;
            end
            if (rsp_err) begin
                err_underflow_q <= 1'b1;
            end
        end
    end

    assign rd_req_en     = rd_req_en_p1;
    assign rd_req_addr   = rd_req_addr_p1;
    assign rd_req_mdata  = rd_req_mdata_p1;
    assign rsp_valid     = rsp_valid_p1;
    assign rsp_seq       = rsp_seq_p1;
    assign rsp_data      = rsp_data_p1;
    assign err_underflow = err_underflow_q;

    // Idle also waits for the request still sitting in the output register.
    always_comb begin
        any_outst = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (outst[i] != '0) begin
                any_outst = 1'b1;
            end
        end
    end

    assign idle = !any_outst && !rd_req_en_p1;

`ifdef RD_ARB_STATS_EN
    logic [31:0] stat_cnt [NREQ];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREQ; i++) begin
                stat_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (stat_clr) begin
                    stat_cnt[i] <= '0;
                end else if (gnt[i]) begin
                    stat_cnt[i] <= stat_cnt[i] + 32'd1;
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < NREQ; g++) begin : g_stat
            assign stat_req_cnt[g*32 +: 32] = stat_cnt[g];
        end
    endgenerate
`endif

endmodule

// File: tb/tb_afu_rd_arbiter.sv
module tb_afu_rd_arbiter;

    localparam int ADDR_LMT    = 20;
    localparam int MDATA       = 14;
    localparam int CACHE_WIDTH = 512;
    localparam int NREQ        = 4;
    localparam int MAX_OUTST   = 4;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ*ADDR_LMT-1:0] req_addr;
    logic [NREQ-1:0]          req_ready;
    logic                     drain;
    logic                     idle;
    logic [ADDR_LMT-1:0]      rd_req_addr;
    logic [MDATA-1:0]         rd_req_mdata;
    logic                     rd_req_en;
    logic                     rd_req_almostfull;
    logic                     rd_rsp_valid;
    logic [MDATA-1:0]         rd_rsp_mdata;
    logic [CACHE_WIDTH-1:0]   rd_rsp_data;
    logic [NREQ-1:0]          rsp_valid;
    logic [7:0]               rsp_seq;
    logic [CACHE_WIDTH-1:0]   rsp_data;
    logic                     err_underflow;
`ifdef RD_ARB_STATS_EN
    logic                     stat_clr = 1'b0;
    logic [NREQ*32-1:0]       stat_req_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    afu_rd_arbiter #(
        .ADDR_LMT    (ADDR_LMT),
        .MDATA       (MDATA),
        .CACHE_WIDTH (CACHE_WIDTH),
        .NREQ        (NREQ),
        .MAX_OUTST   (MAX_OUTST)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .req_valid         (req_valid),
        .req_addr          (req_addr),
        .req_ready         (req_ready),
        .drain             (drain),
        .idle              (idle),
`ifdef RD_ARB_STATS_EN
        .stat_clr          (stat_clr),
        .stat_req_cnt      (stat_req_cnt),
`endif
        .rd_req_addr       (rd_req_addr),
        .rd_req_mdata      (rd_req_mdata),
        .rd_req_en         (rd_req_en),
        .rd_req_almostfull (rd_req_almostfull),
        .rd_rsp_valid      (rd_rsp_valid),
        .rd_rsp_mdata      (rd_rsp_mdata),
        .rd_rsp_data       (rd_rsp_data),
        .rsp_valid         (rsp_valid),
        .rsp_seq           (rsp_seq),
        .rsp_data          (rsp_data),
        .err_underflow     (err_underflow)
    );

    typedef struct {
        logic [3:0]  vld;
        logic [19:0] a0;
        logic        af;
        logic        dr;
        logic        rv;
        logic [13:0] rmd;
        logic [3:0]  rdy;
        logic        en;
        logic [19:0] addr;
        logic [13:0] md;
        logic        idl;
        logic [3:0]  rspv;
        logic [7:0]  seq;
        logic        err;
    } vec_t;

    localparam int NROWS = 37;
    vec_t tbl [NROWS];

    function automatic vec_t v(input logic [3:0] vld, input logic [19:0] a0,
                               input logic af, input logic dr, input logic rv,
                               input logic [13:0] rmd, input logic [3:0] rdy,
                               input logic en, input logic [19:0] addr,
                               input logic [13:0] md, input logic idl,
                               input logic [3:0] rspv, input logic [7:0] seq,
                               input logic err);
        vec_t r;
        r.vld = vld; r.a0 = a0; r.af = af; r.dr = dr; r.rv = rv; r.rmd = rmd;
        r.rdy = rdy; r.en = en; r.addr = addr; r.md = md; r.idl = idl;
        r.rspv = rspv; r.seq = seq; r.err = err;
        return r;
    endfunction

    function automatic logic [CACHE_WIDTH-1:0] pat(input logic [13:0] m);
        logic [CACHE_WIDTH-1:0] r;
        for (int i = 0; i < CACHE_WIDTH / 16; i++) begin
            r[i*16 +: 16] = {2'b01, m} ^ 16'(i * 37);
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] vld, input logic [19:0] a0, input logic af,
                         input logic dr, input logic rv, input logic [13:0] rmd);
        req_valid         = vld;
        req_addr          = {20'hA0003, 20'hA0002, 20'hA0001, a0};
        rd_req_almostfull = af;
        drain             = dr;
        rd_rsp_valid      = rv;
        rd_rsp_mdata      = rmd;
        rd_rsp_data       = rv ? pat(rmd) : '0;
    endtask

    logic [13:0] prev_rmd;

    initial begin
        // Single requester 0: four back-to-back issues, then blocked at MAX_OUTST=4.
        tbl[0]  = v(4'h1, 20'h10, 0, 0, 0, 14'h000, 4'h1, 0, 20'h0,     14'h000, 1, 4'h0, 8'd0, 0);
        tbl[1]  = v(4'h1, 20'h11, 0, 0, 0, 14'h000, 4'h1, 1, 20'h10,    14'h000, 0, 4'h0, 8'd0, 0);
        tbl[2]  = v(4'h1, 20'h12, 0, 0, 0, 14'h000, 4'h1, 1, 20'h11,    14'h004, 0, 4'h0, 8'd0, 0);
        tbl[3]  = v(4'h1, 20'h13, 0, 0, 0, 14'h000, 4'h1, 1, 20'h12,    14'h008, 0, 4'h0, 8'd0, 0);
        tbl[4]  = v(4'h1, 20'h20, 0, 0, 0, 14'h000, 4'h0, 1, 20'h13,    14'h00C, 0, 4'h0, 8'd0, 0);
        // All valid: rotation skips requester 0 until a response frees a slot.
        tbl[5]  = v(4'hF, 20'h20, 0, 0, 0, 14'h000, 4'h2, 0, 20'h0,     14'h000, 0, 4'h0, 8'd0, 0);
        tbl[6]  = v(4'hF, 20'h20, 0, 0, 0, 14'h000, 4'h4, 1, 20'hA0001, 14'h001, 0, 4'h0, 8'd0, 0);
        tbl[7]  = v(4'hF, 20'h20, 0, 0, 0, 14'h000, 4'h8, 1, 20'hA0002, 14'h002, 0, 4'h0, 8'd0, 0);
        tbl[8]  = v(4'hF, 20'h20, 0, 0, 1, 14'h000, 4'h2, 1, 20'hA0003, 14'h003, 0, 4'h0, 8'd0, 0);
        tbl[9]  = v(4'hF, 20'h20, 0, 0, 0, 14'h000, 4'h4, 1, 20'hA0001, 14'h005, 0, 4'h1, 8'd0, 0);
        tbl[10] = v(4'hF, 20'h20, 0, 0, 0, 14'h000, 4'h8, 1, 20'hA0002, 14'h006, 0, 4'h0, 8'd0, 0);
        tbl[11] = v(4'hF, 20'h20, 0, 0, 0, 14'h000, 4'h1, 1, 20'hA0003, 14'h007, 0, 4'h0, 8'd0, 0);
        tbl[12] = v(4'h0, 20'h20, 0, 0, 0, 14'h000, 4'h0, 1, 20'h20,    14'h010, 0, 4'h0, 8'd0, 0);
        // Almost-full held for five cycles.
        for (int r = 13; r < 18; r++) begin
            tbl[r] = v(4'hF, 20'h20, 1, 0, 0, 14'h000, 4'h0, 0, 20'h0, 14'h000, 0, 4'h0, 8'd0, 0);
        end
        tbl[18] = v(4'h2, 20'h20, 0, 0, 0, 14'h000, 4'h2, 0, 20'h0,     14'h000, 0, 4'h0, 8'd0, 0);
        tbl[19] = v(4'h0, 20'h20, 0, 0, 0, 14'h000, 4'h0, 1, 20'hA0001, 14'h009, 0, 4'h0, 8'd0, 0);
        // Out-of-order responses, one per cycle.
        tbl[20] = v(4'h0, 20'h20, 0, 0, 1, 14'h005, 4'h0, 0, 20'h0, 14'h000, 0, 4'h0, 8'd0, 0);
        tbl[21] = v(4'h0, 20'h20, 0, 0, 1, 14'h001, 4'h0, 0, 20'h0, 14'h000, 0, 4'h2, 8'd1, 0);
        tbl[22] = v(4'h0, 20'h20, 0, 0, 1, 14'h004, 4'h0, 0, 20'h0, 14'h000, 0, 4'h2, 8'd0, 0);
        tbl[23] = v(4'h0, 20'h20, 0, 0, 1, 14'h008, 4'h0, 0, 20'h0, 14'h000, 0, 4'h1, 8'd1, 0);
        tbl[24] = v(4'h0, 20'h20, 0, 0, 1, 14'h00C, 4'h0, 0, 20'h0, 14'h000, 0, 4'h1, 8'd2, 0);
        tbl[25] = v(4'h0, 20'h20, 0, 0, 1, 14'h010, 4'h0, 0, 20'h0, 14'h000, 0, 4'h1, 8'd3, 0);
        tbl[26] = v(4'h0, 20'h20, 0, 0, 1, 14'h009, 4'h0, 0, 20'h0, 14'h000, 0, 4'h1, 8'd4, 0);
        tbl[27] = v(4'h0, 20'h20, 0, 0, 1, 14'h002, 4'h0, 0, 20'h0, 14'h000, 0, 4'h2, 8'd2, 0);
        tbl[28] = v(4'h0, 20'h20, 0, 0, 1, 14'h003, 4'h0, 0, 20'h0, 14'h000, 0, 4'h4, 8'd0, 0);
        // Third outstanding read, then drain with three reads in flight.
        tbl[29] = v(4'h1, 20'h30, 0, 0, 0, 14'h000, 4'h1, 0, 20'h0,  14'h000, 0, 4'h8, 8'd0, 0);
        tbl[30] = v(4'hF, 20'h30, 0, 1, 0, 14'h000, 4'h0, 1, 20'h30, 14'h014, 0, 4'h0, 8'd0, 0);
        tbl[31] = v(4'hF, 20'h30, 0, 1, 1, 14'h014, 4'h0, 0, 20'h0,  14'h000, 0, 4'h0, 8'd0, 0);
        tbl[32] = v(4'hF, 20'h30, 0, 1, 1, 14'h006, 4'h0, 0, 20'h0,  14'h000, 0, 4'h1, 8'd5, 0);
        tbl[33] = v(4'hF, 20'h30, 0, 1, 1, 14'h007, 4'h0, 0, 20'h0,  14'h000, 0, 4'h4, 8'd1, 0);
        tbl[34] = v(4'hF, 20'h30, 0, 1, 0, 14'h000, 4'h0, 0, 20'h0,  14'h000, 1, 4'h8, 8'd1, 0);
        // Response to requester 1 which has nothing outstanding.
        tbl[35] = v(4'hF, 20'h30, 0, 1, 1, 14'h001, 4'h0, 0, 20'h0,  14'h000, 1, 4'h0, 8'd0, 0);
        tbl[36] = v(4'h0, 20'h30, 0, 0, 0, 14'h000, 4'h0, 0, 20'h0,  14'h000, 1, 4'h2, 8'd0, 1);

        reset_n = 1'b0;
        drive(4'h0, 20'h0, 1'b0, 1'b0, 1'b0, 14'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset rd_req_en",     32'(rd_req_en),     32'h0);
        chk("reset rd_req_addr",   32'(rd_req_addr),   32'h0);
        chk("reset rd_req_mdata",  32'(rd_req_mdata),  32'h0);
        chk("reset rsp_valid",     32'(rsp_valid),     32'h0);
        chk("reset rsp_seq",       32'(rsp_seq),       32'h0);
        chk("reset rsp_data",      32'(|rsp_data),     32'h0);
        chk("reset err_underflow", 32'(err_underflow), 32'h0);
        chk("reset idle",          32'(idle),          32'h1);
        reset_n = 1'b1;

        prev_rmd = '0;
        for (int r = 0; r < NROWS; r++) begin
            @(posedge clk);
            #1;
            drive(tbl[r].vld, tbl[r].a0, tbl[r].af, tbl[r].dr, tbl[r].rv, tbl[r].rmd);
            #2;
            chk($sformatf("row%0d req_ready", r), 32'(req_ready), 32'(tbl[r].rdy));
            chk($sformatf("row%0d rd_req_en", r), 32'(rd_req_en), 32'(tbl[r].en));
            if (tbl[r].en) begin
                chk($sformatf("row%0d rd_req_addr", r),  32'(rd_req_addr),  32'(tbl[r].addr));
                chk($sformatf("row%0d rd_req_mdata", r), 32'(rd_req_mdata), 32'(tbl[r].md));
            end
            chk($sformatf("row%0d idle", r),      32'(idle),      32'(tbl[r].idl));
            chk($sformatf("row%0d rsp_valid", r), 32'(rsp_valid), 32'(tbl[r].rspv));
            if (tbl[r].rspv != 4'h0) begin
                chk($sformatf("row%0d rsp_seq", r), 32'(rsp_seq), 32'(tbl[r].seq));
                checks++;
                if (rsp_data !== pat(prev_rmd)) begin
                    errors++;
                    $display("FAIL row%0d rsp_data actual=%0h required=%0h",
                             r, rsp_data[31:0], pat(prev_rmd) >> 0 & 32'hFFFFFFFF);
                end
            end
            chk($sformatf("row%0d err_underflow", r), 32'(err_underflow), 32'(tbl[r].err));
            prev_rmd = tbl[r].rmd;
        end

        // Reset in the middle of traffic: pointer, sequence numbers and the
        // sticky error must all clear immediately.
        @(posedge clk);
        #1;
        drive(4'hF, 20'h30, 1'b0, 1'b0, 1'b0, 14'h0);
        #2;
        chk("pre-reset req_ready", 32'(req_ready), 32'h2);
        @(posedge clk);
        #1;
        chk("pre-reset rd_req_en",    32'(rd_req_en),    32'h1);
        chk("pre-reset rd_req_mdata", 32'(rd_req_mdata), 32'h00D);
        reset_n = 1'b0;
        #1;
        chk("midreset rd_req_en",     32'(rd_req_en),     32'h0);
        chk("midreset rd_req_mdata",  32'(rd_req_mdata),  32'h0);
        chk("midreset err_underflow", 32'(err_underflow), 32'h0);
        chk("midreset idle",          32'(idle),          32'h1);
        chk("midreset req_ready",     32'(req_ready),     32'h1);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post-reset rd_req_en",    32'(rd_req_en),    32'h1);
        chk("post-reset rd_req_addr",  32'(rd_req_addr),  32'h30);
        chk("post-reset rd_req_mdata", 32'(rd_req_mdata), 32'h000);
        drive(4'h0, 20'h0, 1'b0, 1'b0, 1'b0, 14'h0);
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/afu_rd_arbiter.md
# afu_rd_arbiter

Shares the single AFU read-request/read-response channel between NREQ independent read requesters, for example the edge stream, the vertex-property fetch and the frontier fetch of the BFS datapath. Arbitration is round-robin. Each issued request is tagged through mdata with the requester id and a sequence number, and outstanding reads are limited per requester. Every response is routed back to the requester that issued it. A drain/idle pair lets the top-level FSM form a barrier between BFS levels. The block sits between the datapath read clients and the AFU read ports.

## Interface
- ADDR_LMT, 20, cache-line address width
- MDATA, 14, mdata width; must be ≥ ID_W+SEQ_W
- CACHE_WIDTH, 512, line width
- NREQ, 4, number of requesters (2..8); ID_W = clog2(NREQ)
- MAX_OUTST, 16, outstanding-read limit per requester (1..255)

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  requester i has an address ready
- req_addr  in  NREQ*ADDR_LMT  slice i = address of requester i
- req_ready  out  NREQ  one-hot grant; a transfer occurs when valid and ready are both high
- drain  in  1  blocks all new grants while high
- idle  out  1  no outstanding reads and no request pending issue
- rd_req_addr  out  ADDR_LMT  registered request address
- rd_req_mdata  out  MDATA  registered tag
- rd_req_en  out  1  registered request strobe
- rd_req_almostfull  in  1  backpressure from the request channel
- rd_rsp_valid  in  1  response strobe
- rd_rsp_mdata  in  MDATA  response tag
- rd_rsp_data  in  CACHE_WIDTH  response data
- rsp_valid  out  NREQ  one-hot response delivery
- rsp_seq  out  SEQ_W  sequence number of the delivered response
- rsp_data  out  CACHE_WIDTH  response data, shared by all requesters
- err_underflow  out  1  sticky: a response arrived for a requester with zero outstanding reads

## Operation
- Eligibility: requester i is eligible when req_valid[i] is high and outst[i] < MAX_OUTST.
- Grant condition: a grant happens when !rd_req_almostfull, !drain, and at least one requester is eligible. At most one grant per cycle.
- Round-robin: search starts at pointer ptr. After a grant, ptr ← (winner+1) mod NREQ. ptr is unchanged when there is no grant.
- req_ready is combinational from the current eligibility, ptr, almostfull and drain.
- Issue on grant:
  - register rd_req_addr ← req_addr[winner]
  - register rd_req_mdata ← {zeros, seq[winner], winner}: bits [ID_W-1:0] = id, next SEQ_W=8 bits = sequence number
  - register rd_req_en ← 1
  - seq[winner] increments modulo 256
  - outst[winner] increments
- Response with id = rd_rsp_mdata[ID_W-1:0]:
  - register rsp_valid[id], rsp_seq and rsp_data
  - outst[id] decrements
- Out-of-order responses are legal. Requesters reorder using rsp_seq.
- Same counter incremented and decremented in one cycle: net unchanged.
- Response to a requester with outst = 0: counter stays at 0 and err_underflow is set. err_underflow clears only on reset.
- Response with id ≥ NREQ: dropped, and err_underflow is set.
- idle = (all outst == 0) && !rd_req_en. The top-level FSM raises drain and waits for idle to form the level barrier.

## Timing
- Reset values: rd_req_en=0, rd_req_addr=0, rd_req_mdata=0, rsp_valid=0, rsp_seq=0, rsp_data=0, err_underflow=0, idle=1.
- Internal reset values: ptr=0, all seq=0, all outst=0.
- Grant in cycle N → rd_req_en high in cycle N+1 for exactly one cycle.
- rd_req_almostfull is sampled in the grant cycle.
- rd_rsp_valid in cycle M → rsp_valid in cycle M+1. Throughput is one response per cycle.
- drain taking effect: drain asserted in cycle N means no grant in cycle N. A request already registered still issues in N+1.
- Reset mid-operation: all state clears immediately. Responses from reads issued before reset raise err_underflow; the top level must not reset with reads in flight.
- Counter width is clog2(MAX_OUTST+1).

## Configuration
- RD_ARB_STATS_EN defined:
  - adds input stat_clr (1 bit)
  - adds output stat_req_cnt (NREQ*32): per-requester issued-read counters
  - counters increment on each grant, wrap at 2^32, and clear on reset or on stat_clr
  - when stat_clr and a grant occur in the same cycle, the counter becomes 0
- Not defined: these ports and the counters are absent. All other behaviour is identical.

## Structure
- Package afu_rd_arb_pkg holds:
  - SEQ_W = 8
  - mdata field offsets: ID_LSB = 0, SEQ_LSB = ID_W
  - the clog2-based width function
- Sub-module rr_arbiter: NREQ-wide rotating-priority grant with a registered pointer and a grant-accept input. It is instantiated once.

## Test plan
- Single requester, NREQ=4: req_valid=0001, addrs 0x10..0x13, no backpressure → four rd_req_en pulses on consecutive cycles with mdata 0x000, 0x004, 0x008, 0x00C.
- All four requesters valid continuously → grant order 0,1,2,3,0,… with one grant per cycle.
- MAX_OUTST=2, no responses → requester 0 is granted twice, then req_ready[0]=0 and other requesters proceed. One response with tag id 0 → requester 0 is granted again on the next eligible turn.
- rd_req_almostfull held high for 5 cycles → no rd_req_en during that window; issue resumes the cycle after almostfull falls.
- Out-of-order responses with mdata 0x005 then 0x001 → rsp_valid[1] with rsp_seq=1, then rsp_valid[1] with rsp_seq=0. Response to a requester with outst=0 → err_underflow=1.
- Raise drain with 3 reads outstanding → no new grants, idle=0. After the 3 responses, idle=1 in the cycle after the last rsp_valid.
